// File: rtl/mult_sweep_scorer_if.sv
// mult_sweep_scorer_if: operand/result bus between the sweep scorer and the multiplier under test
interface mult_sweep_scorer_if #(parameter int W = 2);
  logic             start;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic             op_valid;
  logic [2*W-1:0]   product;
  logic             busy;
  logic             done;
  logic [2*W:0]     pass_cnt;
  logic [2*W:0]     fail_cnt;
  logic             all_pass;
  logic [W-1:0]     first_fail_a;
  logic [W-1:0]     first_fail_b;
  logic [2*W-1:0]   first_fail_p;
  logic             first_fail_vld;
  modport master (
    input  start, product,
    output op_a, op_b, op_valid, busy, done, pass_cnt, fail_cnt, all_pass,
           first_fail_a, first_fail_b, first_fail_p, first_fail_vld
  );
  modport slave (
    output start, product,
    input  op_a, op_b, op_valid, busy, done, pass_cnt, fail_cnt, all_pass,
           first_fail_a, first_fail_b, first_fail_p, first_fail_vld
  );
endinterface

// File: rtl/mult_sweep_scorer.sv
// mult_sweep_scorer: exhaustive operand sweep of a W-bit multiplier with pass/fail scoring.
// Define SWEEP_ERRLOG_EN to latch the first mismatching vector into first_fail_*.
module mult_sweep_scorer #(
  parameter int W   = 2,
  parameter int LAT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_sweep_scorer_if.master bus
);
  localparam int N = 2 * W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t         state;
  logic [N-1:0]   vec;
  logic [1:0]     dcnt;
  logic           cmp_vld;
  logic [N-1:0]   cmp_vec;
  logic [N-1:0]   exp_p;
  logic           hit;
  logic           accept;
  assign accept   = (state == IDLE) && bus.start;
  assign bus.op_a = vec[N-1:W];
  assign bus.op_b = vec[W-1:0];
  assign exp_p    = {{W{1'b0}}, cmp_vec[N-1:W]} * {{W{1'b0}}, cmp_vec[W-1:0]};
  assign hit      = exp_p == bus.product;
  // The compared vector trails the presented one by LAT cycles so it lines up with product.
  if (LAT == 0) begin : g_nolat
    assign cmp_vld = bus.op_valid;
    assign cmp_vec = vec;
  end else begin : g_lat
    logic [LAT-1:0] dv;
    logic [N-1:0]   dvec [LAT];
    // Valid/vector delay line matching the multiplier pipeline depth
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dv <= '0;
        for (int i = 0; i < LAT; i++) dvec[i] <= '0;
      end else begin
        dv      <= LAT'({dv, bus.op_valid});
        dvec[0] <= vec;
        for (int i = 1; i < LAT; i++) dvec[i] <= dvec[i-1];
      end
    end
    assign cmp_vld = dv[LAT-1];
    assign cmp_vec = dvec[LAT-1];
  end
  // Sweep sequencing, registered status outputs and result counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      vec          <= '0;
      dcnt         <= '0;
      bus.op_valid <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.all_pass <= 1'b0;
      bus.pass_cnt <= '0;
      bus.fail_cnt <= '0;
    end else begin
      bus.done <= state == DONE;
      case (state)
        IDLE: if (bus.start) begin
          state        <= RUN;
          vec          <= '0;
          bus.op_valid <= 1'b1;
          bus.busy     <= 1'b1;
          bus.all_pass <= 1'b0;
        end
        RUN: if (vec == '1) begin
          state        <= (LAT == 0) ? DONE : DRAIN;
          bus.op_valid <= 1'b0;
          bus.busy     <= LAT != 0;
          dcnt         <= '0;
        end else begin
          vec <= vec + 1'b1;
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == 2'(LAT - 1)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          bus.all_pass <= bus.fail_cnt == '0;
        end
      endcase
      if (accept) begin
        bus.pass_cnt <= '0;
        bus.fail_cnt <= '0;
      end else if (cmp_vld) begin
        if (hit) bus.pass_cnt <= bus.pass_cnt + 1'b1;
        else     bus.fail_cnt <= bus.fail_cnt + 1'b1;
      end
    end
  end
`ifdef SWEEP_ERRLOG_EN
  // Capture only the first mismatch of a sweep; cleared when a new sweep is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || accept) begin
      if (!rst_n || accept) begin
        bus.first_fail_a   <= '0;
        bus.first_fail_b   <= '0;
        bus.first_fail_p   <= '0;
        bus.first_fail_vld <= 1'b0;
      end
    end else if (cmp_vld && !hit && !bus.first_fail_vld) begin
      bus.first_fail_a   <= cmp_vec[N-1:W];
      bus.first_fail_b   <= cmp_vec[W-1:0];
      bus.first_fail_p   <= bus.product;
      bus.first_fail_vld <= 1'b1;
    end
  end
`else
  assign bus.first_fail_a   = '0;
  assign bus.first_fail_b   = '0;
  assign bus.first_fail_p   = '0;
  assign bus.first_fail_vld = 1'b0;
`endif
endmodule

// File: tb/tb_mult_sweep_scorer.sv
// tb_mult_sweep_scorer: directed sweeps against exact, broken and pipelined multipliers
module tb_mult_sweep_scorer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_n = 0;
  int   total = 0;
  int   mode = 0;
  logic [3:0] p0, s1, s2;
  always #5 clk = ~clk;
  mult_sweep_scorer_if #(.W(2)) b0 ();
  mult_sweep_scorer_if #(.W(2)) b2 ();
  mult_sweep_scorer #(.W(2), .LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mult_sweep_scorer #(.W(2), .LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  // mode 0: exact, 1: product tied 0, 2: product bit 0 forced low
  always_comb begin
    p0 = {2'b0, b0.op_a} * {2'b0, b0.op_b};
    b0.product = (mode == 1) ? 4'd0 : (mode == 2) ? (p0 & 4'b1110) : p0;
  end
  // two-stage registered exact multiplier for the LAT=2 scorer
  always_ff @(posedge clk) begin
    s1 <= {2'b0, b2.op_a} * {2'b0, b2.op_b};
    s2 <= s1;
  end
  assign b2.product = s2;
  initial begin
    b0.start = 1'b0;
    b2.start = 1'b0;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic sweep(input bit which, output int cyc, output int errs);
    logic dn, ov, bz;
    logic [3:0] v;
    int lat;
    lat = which ? 2 : 0;
    errs = 0;
    @(negedge clk);
    if (which) b2.start = 1'b1; else b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    b2.start = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      dn = which ? b2.done : b0.done;
      ov = which ? b2.op_valid : b0.op_valid;
      bz = which ? b2.busy : b0.busy;
      v  = which ? {b2.op_a, b2.op_b} : {b0.op_a, b0.op_b};
      if (dn) break;
      if (ov !== (cyc < 16) || bz !== (cyc < 16 + lat) || (cyc < 16 && v !== cyc[3:0])) errs++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({b0.op_a, b0.op_b, b0.op_valid, b0.busy, b0.done, b0.all_pass} !== 8'd0)
      $display("FAIL reset_ctrl: got %b want 0", {b0.op_a, b0.op_b, b0.op_valid, b0.busy, b0.done, b0.all_pass});
    else pass_n++;
    total++;
    if ({b0.pass_cnt, b0.fail_cnt, b0.first_fail_vld} !== 11'd0)
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", b0.pass_cnt, b0.fail_cnt);
    else pass_n++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exact();
    int cyc, errs;
    mode = 0;
    sweep(1'b0, cyc, errs);
    total++; if (cyc !== 17) $display("FAIL exact_latency: got %0d want 17", cyc); else pass_n++;
    total++; if (errs !== 0) $display("FAIL exact_seq: got %0d errs want 0", errs); else pass_n++;
    total++; if (b0.pass_cnt !== 5'd16 || b0.fail_cnt !== 5'd0)
      $display("FAIL exact_cnt: got %0d/%0d want 16/0", b0.pass_cnt, b0.fail_cnt); else pass_n++;
    total++; if (b0.all_pass !== 1'b1) $display("FAIL exact_all_pass: got %b want 1", b0.all_pass); else pass_n++;
  endtask

  task automatic test_zero();
    int cyc, errs;
    mode = 1;
    sweep(1'b0, cyc, errs);
    total++; if (b0.pass_cnt !== 5'd7 || b0.fail_cnt !== 5'd9)
      $display("FAIL zero_cnt: got %0d/%0d want 7/9", b0.pass_cnt, b0.fail_cnt); else pass_n++;
    total++; if (b0.all_pass !== 1'b0) $display("FAIL zero_all_pass: got %b want 0", b0.all_pass); else pass_n++;
    total++; if (b0.done !== 1'b1 || cyc !== 17) $display("FAIL zero_done: got %0d want 17", cyc); else pass_n++;
  endtask

  task automatic test_lat2();
    int cyc, errs;
    sweep(1'b1, cyc, errs);
    total++; if (cyc !== 19) $display("FAIL lat2_latency: got %0d want 19", cyc); else pass_n++;
    total++; if (errs !== 0) $display("FAIL lat2_seq: got %0d errs want 0", errs); else pass_n++;
    total++; if (b2.pass_cnt !== 5'd16 || b2.fail_cnt !== 5'd0 || b2.all_pass !== 1'b1)
      $display("FAIL lat2_cnt: got %0d/%0d ap=%b want 16/0 ap=1", b2.pass_cnt, b2.fail_cnt, b2.all_pass); else pass_n++;
  endtask

  task automatic test_errlog();
    int cyc, errs;
    mode = 2;
    sweep(1'b0, cyc, errs);
    total++; if (b0.pass_cnt !== 5'd12 || b0.fail_cnt !== 5'd4)
      $display("FAIL bit0_cnt: got %0d/%0d want 12/4", b0.pass_cnt, b0.fail_cnt); else pass_n++;
`ifdef SWEEP_ERRLOG_EN
    total++; if ({b0.first_fail_a, b0.first_fail_b, b0.first_fail_p, b0.first_fail_vld} !== {2'd1, 2'd1, 4'd0, 1'b1})
      $display("FAIL errlog: got a=%0d b=%0d p=%0d v=%b want 1 1 0 1",
               b0.first_fail_a, b0.first_fail_b, b0.first_fail_p, b0.first_fail_vld); else pass_n++;
`else
    total++; if ({b0.first_fail_a, b0.first_fail_b, b0.first_fail_p, b0.first_fail_vld} !== 9'd0)
      $display("FAIL errlog_off: got a=%0d b=%0d p=%0d v=%b want all 0",
               b0.first_fail_a, b0.first_fail_b, b0.first_fail_p, b0.first_fail_vld); else pass_n++;
`endif
  endtask

  task automatic test_reset_mid();
    int cyc, errs;
    mode = 0;
    @(negedge clk);
    b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    total++; if ({b0.op_a, b0.op_b} !== 4'd5 || b0.pass_cnt !== 5'd5)
      $display("FAIL mid_pre: got vec=%0d pass=%0d want 5/5", {b0.op_a, b0.op_b}, b0.pass_cnt); else pass_n++;
    rst_n = 1'b0;
    #1;
    total++; if ({b0.op_a, b0.op_b, b0.op_valid, b0.busy, b0.done, b0.all_pass, b0.pass_cnt, b0.fail_cnt} !== 18'd0)
      $display("FAIL mid_async: got vec=%0d vld=%b busy=%b cnt=%0d/%0d want all 0",
               {b0.op_a, b0.op_b}, b0.op_valid, b0.busy, b0.pass_cnt, b0.fail_cnt); else pass_n++;
    @(negedge clk);
    rst_n = 1'b1;
    sweep(1'b0, cyc, errs);
    total++; if (cyc !== 17 || errs !== 0 || b0.pass_cnt !== 5'd16 || b0.fail_cnt !== 5'd0)
      $display("FAIL mid_resweep: got cyc=%0d errs=%0d cnt=%0d/%0d want 17 0 16/0", cyc, errs, b0.pass_cnt, b0.fail_cnt);
    else pass_n++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    mode = 1;
    @(negedge clk);
    b0.start = 1'b1;
    @(posedge clk); #1;
    for (cyc = 0; cyc < 40 && !b0.done; cyc++) begin
      @(posedge clk); #1;
    end
    total++; if (cyc !== 17 || b0.fail_cnt !== 5'd9)
      $display("FAIL b2b_first: got cyc=%0d fail=%0d want 17/9", cyc, b0.fail_cnt); else pass_n++;
    mode = 0;
    @(posedge clk); #1;
    total++; if (b0.busy !== 1'b1 || b0.pass_cnt !== 5'd0 || b0.fail_cnt !== 5'd0 || b0.op_valid !== 1'b1)
      $display("FAIL b2b_restart: got busy=%b cnt=%0d/%0d want busy=1 0/0", b0.busy, b0.pass_cnt, b0.fail_cnt);
    else pass_n++;
    for (cyc = 0; cyc < 40 && !b0.done; cyc++) begin
      @(posedge clk); #1;
    end
    b0.start = 1'b0;
    total++; if (cyc !== 17 || b0.pass_cnt !== 5'd16 || b0.all_pass !== 1'b1)
      $display("FAIL b2b_second: got cyc=%0d pass=%0d ap=%b want 17/16/1", cyc, b0.pass_cnt, b0.all_pass); else pass_n++;
    repeat (3) @(posedge clk);
    #1;
    total++; if (b0.busy !== 1'b0 || b0.done !== 1'b0 || b0.pass_cnt !== 5'd16)
      $display("FAIL b2b_idle: got busy=%b done=%b pass=%0d want 0 0 16", b0.busy, b0.done, b0.pass_cnt); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_exact();
    test_zero();
    test_lat2();
    test_errlog();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_n, total);
    $finish;
  end
endmodule

// File: doc/mult_sweep_scorer.md
MULT_SWEEP_SCORER -- requirements
Module: mult_sweep_scorer

Interface
REQ-001 Parameter: W, 2, operand width of the multiplier under test (1..4).
REQ-002 Parameter: LAT, 0, multiplier latency in clock cycles from operand presentation to product valid (0..3).
REQ-003 Port: clk  input  1  single rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request one exhaustive sweep; sampled only in IDLE.
REQ-006 Port: op_a  output  W  operand A driven to the multiplier, registered.
REQ-007 Port: op_b  output  W  operand B driven to the multiplier, registered.
REQ-008 Port: op_valid  output  1  op_a/op_b carry a sweep vector this cycle.
REQ-009 Port: product  input  2W  multiplier result, sampled LAT cycles after its operands.
REQ-010 Port: busy  output  1  high in RUN and DRAIN.
REQ-011 Port: done  output  1  one-cycle registered pulse at sweep completion.
REQ-012 Port: pass_cnt  output  2W+1  vectors whose product matched.
REQ-013 Port: fail_cnt  output  2W+1  vectors whose product mismatched.
REQ-014 Port: all_pass  output  1  high when fail_cnt is 0 and a sweep has completed.
REQ-015 Ports (macro-dependent): first_fail_a W, first_fail_b W, first_fail_p 2W, first_fail_vld 1, all outputs.

Function
REQ-016 States: IDLE, RUN, DRAIN, DONE; a single state register.
REQ-017 IDLE with start=1 at edge t: enter RUN, clear pass_cnt, fail_cnt, all_pass, vector counter, error log.
REQ-018 RUN: vector counter v steps 0..2^(2W)-1 one per cycle; op_a=v[2W-1:W], op_b=v[W-1:0], op_valid=1.
REQ-019 Expected product = op_a*op_b, unsigned, full 2W bits, carried through a LAT-deep valid/expected shift register aligned with op_valid.
REQ-020 Compare in each cycle where the delayed valid is 1; exact 2W-bit equality increments pass_cnt, otherwise fail_cnt, at the next edge.
REQ-021 After the last vector: LAT=0 go straight to DONE; LAT>0 go to DRAIN for exactly LAT cycles with op_valid=0, still comparing.
REQ-022 DONE lasts one cycle: done=1, all_pass=(fail_cnt==0), then IDLE; counts and all_pass hold until the next accepted start.
REQ-023 start ignored outside IDLE; start held high restarts on the IDLE cycle following DONE.
REQ-024 op_a/op_b hold last value when op_valid=0; counters never wrap (2^(2W) fits in 2W+1 bits).
REQ-025 For LAT=0 sweep of 16 vectors: start at edge t, done high in cycle t+17 window (after edge t+17).

Reset
REQ-026 rst_n low forces immediately: state IDLE, op_a=0, op_b=0, op_valid=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, all_pass=0, shift register cleared, error log 0.
REQ-027 Reset mid-sweep aborts; no partial result retained; next start runs a full sweep.

Configuration
REQ-028 Macro SWEEP_ERRLOG_EN defined: first mismatching vector latches op_a, op_b and received product into first_fail_*, first_fail_vld=1; later mismatches do not overwrite; cleared on accepted start.
REQ-029 Macro SWEEP_ERRLOG_EN undefined: first_fail_* ports present, tied to 0, no log registers.

Verification
REQ-030 W=2, LAT=0, exact combinational multiplier, start pulse -> done after 17 cycles, pass_cnt=16, fail_cnt=0, all_pass=1.
REQ-031 W=2, LAT=0, product tied 0 -> pass_cnt=7, fail_cnt=9, all_pass=0.
REQ-032 W=2, LAT=2, two-stage registered exact multiplier -> 2 DRAIN cycles, done after 19 cycles, pass_cnt=16.
REQ-033 SWEEP_ERRLOG_EN, LAT=0, multiplier with product[0] forced 0 -> fail_cnt=4, pass_cnt=12, first_fail_a=1, first_fail_b=1, first_fail_p=0, first_fail_vld=1.
REQ-034 rst_n pulsed low at vector 5 -> all outputs 0 asynchronously; subsequent start yields full 16-vector sweep with correct counts.
REQ-035 start held high continuously -> back-to-back sweeps, one IDLE cycle between DONE and next RUN, counts cleared at each start.
